hazard_ctrl: RTL and testbench

//  Pipeline hazard and trap sequencer for the 5-stage core. Consumes ID's load_dependence, EX branch/trap

---
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and trap sequencer for the 5-stage core: stall/flush/redirect steering,
// a trap drain FSM that waits for the CSR acknowledge, and saturating perf counters.
module hazard_ctrl #(
  parameter int CNT_W             = 32,
  parameter int TRAP_FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_dependence,
  input  logic             ex_branch_taken,
  input  logic             ex_trap,
  input  logic             mem_busy,
  input  logic             trap_ack,
  output logic             pc_stall,
  output logic             if_stall,
  output logic             ex_stall,
  output logic             if_flush,
  output logic             id_flush,
  output logic             pc_redirect,
  output logic             pc_redirect_trap,
  output logic             trap_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    TRAP_FLUSH = 2'd1,
    TRAP_WAIT  = 2'd2
  } state_t;

  localparam int FC_W = (TRAP_FLUSH_CYCLES > 1) ? $clog2(TRAP_FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FC_INIT = FC_W'(TRAP_FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [FC_W-1:0]   fcnt_r;
  logic [FC_W-1:0]   fcnt_nxt_s;
  logic              stall_inc_s;
  logic              flush_inc_s;

  // Next-state and same-cycle control outputs; everything forced low while rst is high
  always_comb begin
    state_nxt_s      = state_r;
    fcnt_nxt_s       = fcnt_r;
    stall_inc_s      = 1'b0;
    flush_inc_s      = 1'b0;
    pc_stall         = 1'b0;
    if_stall         = 1'b0;
    ex_stall         = 1'b0;
    if_flush         = 1'b0;
    id_flush         = 1'b0;
    pc_redirect      = 1'b0;
    pc_redirect_trap = 1'b0;
    trap_busy        = 1'b0;
    if (rst) begin
      state_nxt_s = RUN;
      fcnt_nxt_s  = {FC_W{1'b0}};
    end else begin
      case (state_r)
        RUN: begin
          if (mem_busy) begin
            // EX resolution is frozen with the pipe and re-examined once the LSU frees up
            pc_stall    = 1'b1;
            if_stall    = 1'b1;
            ex_stall    = 1'b1;
            stall_inc_s = 1'b1;
          end else if (ex_trap) begin
            pc_stall    = 1'b1;
            if_flush    = 1'b1;
            id_flush    = 1'b1;
            flush_inc_s = 1'b1;
            state_nxt_s = TRAP_FLUSH;
            fcnt_nxt_s  = FC_INIT;
          end else if (ex_branch_taken) begin
            pc_redirect = 1'b1;
            if_flush    = 1'b1;
            id_flush    = 1'b1;
            flush_inc_s = 1'b1;
          end else if (load_dependence) begin
            pc_stall    = 1'b1;
            if_stall    = 1'b1;
            id_flush    = 1'b1;
            stall_inc_s = 1'b1;
          end else begin
            stall_inc_s = 1'b0;
          end
        end
        TRAP_FLUSH: begin
          pc_stall  = 1'b1;
          if_flush  = 1'b1;
          id_flush  = 1'b1;
          trap_busy = 1'b1;
          if (fcnt_r == {FC_W{1'b0}}) begin
            state_nxt_s = TRAP_WAIT;
          end else begin
            fcnt_nxt_s = fcnt_r - {{(FC_W-1){1'b0}}, 1'b1};
          end
        end
        TRAP_WAIT: begin
          pc_stall  = 1'b1;
          if_flush  = 1'b1;
          id_flush  = 1'b1;
          trap_busy = 1'b1;
          if (trap_ack) begin
            pc_stall         = 1'b0;
            pc_redirect_trap = 1'b1;
            state_nxt_s      = RUN;
          end else begin
            state_nxt_s = TRAP_WAIT;
          end
        end
        default: begin
          state_nxt_s = RUN;
          fcnt_nxt_s  = {FC_W{1'b0}};
        end
      endcase
    end
  end

  // State, drain counter and saturating perf counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= RUN;
      fcnt_r    <= {FC_W{1'b0}};
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      fcnt_r  <= fcnt_nxt_s;
      if (stall_inc_s && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flush_inc_s && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, saturation sequence,
// then random stimulus against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int TFC   = 2;
  localparam int SAT   = 15;

  logic clk = 1'b0;
  logic rst, load_dependence, ex_branch_taken, ex_trap, mem_busy, trap_ack;
  logic pc_stall, if_stall, ex_stall, if_flush, id_flush, pc_redirect, pc_redirect_trap, trap_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .TRAP_FLUSH_CYCLES(TFC)) dut (
    .clk(clk), .rst(rst), .load_dependence(load_dependence), .ex_branch_taken(ex_branch_taken),
    .ex_trap(ex_trap), .mem_busy(mem_busy), .trap_ack(trap_ack),
    .pc_stall(pc_stall), .if_stall(if_stall), .ex_stall(ex_stall), .if_flush(if_flush),
    .id_flush(id_flush), .pc_redirect(pc_redirect), .pc_redirect_trap(pc_redirect_trap),
    .trap_busy(trap_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // {pc_stall, if_stall, ex_stall, if_flush, id_flush, pc_redirect, pc_redirect_trap, trap_busy}
  logic [7:0] outs;
  assign outs = {pc_stall, if_stall, ex_stall, if_flush, id_flush, pc_redirect, pc_redirect_trap, trap_busy};

  typedef struct {
    logic [5:0] in;   // {rst, ld, br, trap, mb, ack}
    logic [7:0] out;
    logic       chk_cnt;
    int         sc;
    int         fc;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(logic [5:0] in, logic [7:0] out, logic chk, int sc, int fc);
    vec_t v;
    v.in = in; v.out = out; v.chk_cnt = chk; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic apply(input logic [5:0] in);
    {rst, load_dependence, ex_branch_taken, ex_trap, mem_busy, trap_ack} = in;
  endtask

  task automatic check_outs(input string name, input logic [7:0] exp);
    n_checks++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b want %b at %0t", name, outs, exp, $time);
    end
  endtask

  task automatic check_cnts(input string name, input int sc, input int fc);
    n_checks++;
    if (stall_cnt !== CNT_W'(sc) || flush_cnt !== CNT_W'(fc)) begin
      n_fail++;
      $display("FAIL %s: stall_cnt/flush_cnt got %0d/%0d want %0d/%0d at %0t",
               name, stall_cnt, flush_cnt, sc, fc, $time);
    end
  endtask

  // Behavioural model: mode 0 = running, 1 = draining (left = flush cycles remaining), 2 = awaiting ack
  int m_mode, m_left, m_sc, m_fc;

  function automatic logic [7:0] model_outs(logic [5:0] in);
    logic r, ld, br, tr, mb, ack;
    {r, ld, br, tr, mb, ack} = in;
    if (r) return 8'b0000_0000;
    if (m_mode == 0) begin
      if (mb) return 8'b1110_0000;
      if (tr) return 8'b1001_1000;
      if (br) return 8'b0001_1100;
      if (ld) return 8'b1100_1000;
      return 8'b0000_0000;
    end
    if (m_mode == 2 && ack) return 8'b0001_1011;
    return 8'b1001_1001;
  endfunction

  task automatic model_step(input logic [5:0] in);
    logic r, ld, br, tr, mb, ack;
    {r, ld, br, tr, mb, ack} = in;
    if (r) begin
      m_mode = 0; m_left = 0; m_sc = 0; m_fc = 0;
    end else if (m_mode == 0) begin
      if (mb || (!tr && !br && ld)) m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
      if (!mb && (tr || br))        m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
      if (!mb && tr) begin m_mode = 1; m_left = TFC; end
    end else if (m_mode == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) m_mode = 2;
    end else begin
      if (ack) m_mode = 0;
    end
  endtask

  initial begin
    tbl[0]  = mk(6'b100000, 8'b00000000, 1'b0, 0, 0);
    tbl[1]  = mk(6'b100000, 8'b00000000, 1'b1, 0, 0);
    tbl[2]  = mk(6'b000000, 8'b00000000, 1'b1, 0, 0);
    tbl[3]  = mk(6'b010000, 8'b11001000, 1'b1, 0, 0);
    tbl[4]  = mk(6'b000000, 8'b00000000, 1'b1, 1, 0);
    tbl[5]  = mk(6'b001010, 8'b11100000, 1'b1, 1, 0);
    tbl[6]  = mk(6'b001010, 8'b11100000, 1'b1, 2, 0);
    tbl[7]  = mk(6'b001010, 8'b11100000, 1'b1, 3, 0);
    tbl[8]  = mk(6'b001000, 8'b00011100, 1'b1, 4, 0);
    tbl[9]  = mk(6'b000000, 8'b00000000, 1'b1, 4, 1);
    tbl[10] = mk(6'b011000, 8'b00011100, 1'b1, 4, 1);
    tbl[11] = mk(6'b000100, 8'b10011000, 1'b1, 4, 2);
    tbl[12] = mk(6'b011011, 8'b10011001, 1'b1, 4, 3);
    tbl[13] = mk(6'b000001, 8'b10011001, 1'b1, 4, 3);
    tbl[14] = mk(6'b000000, 8'b10011001, 1'b1, 4, 3);
    tbl[15] = mk(6'b000000, 8'b10011001, 1'b1, 4, 3);
    tbl[16] = mk(6'b000001, 8'b00011011, 1'b1, 4, 3);
    tbl[17] = mk(6'b000000, 8'b00000000, 1'b1, 4, 3);
    tbl[18] = mk(6'b000100, 8'b10011000, 1'b1, 4, 3);
    tbl[19] = mk(6'b000000, 8'b10011001, 1'b1, 4, 4);
    tbl[20] = mk(6'b000000, 8'b10011001, 1'b1, 4, 4);
    tbl[21] = mk(6'b000000, 8'b10011001, 1'b1, 4, 4);
    tbl[22] = mk(6'b100001, 8'b00000000, 1'b1, 4, 4);
    tbl[23] = mk(6'b000000, 8'b00000000, 1'b1, 0, 0);
    tbl[24] = mk(6'b000110, 8'b11100000, 1'b1, 0, 0);
    tbl[25] = mk(6'b000100, 8'b10011000, 1'b1, 1, 0);
    tbl[26] = mk(6'b000000, 8'b10011001, 1'b1, 1, 1);
    tbl[27] = mk(6'b000000, 8'b10011001, 1'b1, 1, 1);
    tbl[28] = mk(6'b000001, 8'b00011011, 1'b1, 1, 1);
    tbl[29] = mk(6'b000000, 8'b00000000, 1'b1, 1, 1);

    apply(6'b100000);
    @(posedge clk); #1;

    // Directed table: drive after the edge, compare at the falling edge
    for (int i = 0; i < 30; i++) begin
      apply(tbl[i].in);
      #4;
      check_outs($sformatf("vec%0d", i), tbl[i].out);
      if (tbl[i].chk_cnt) check_cnts($sformatf("vec%0d_cnt", i), tbl[i].sc, tbl[i].fc);
      @(posedge clk); #1;
    end

    // Saturation: 20 cycles of load_dependence on a 4-bit counter
    apply(6'b100000);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      apply(6'b010000);
      @(posedge clk); #1;
    end
    apply(6'b000000);
    #4;
    check_cnts("stall_sat", SAT, 0);
    @(posedge clk); #1;

    // Random stimulus against the model
    apply(6'b100000);
    m_mode = 0; m_left = 0; m_sc = 0; m_fc = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 2000; i++) begin
      logic [5:0] in;
      in[5] = ($urandom_range(0, 99) < 2);
      in[4] = ($urandom_range(0, 99) < 30);
      in[3] = ($urandom_range(0, 99) < 20);
      in[2] = ($urandom_range(0, 99) < 6);
      in[1] = ($urandom_range(0, 99) < 20);
      in[0] = ($urandom_range(0, 99) < 35);
      apply(in);
      #4;
      check_outs($sformatf("rnd%0d", i), model_outs(in));
      check_cnts($sformatf("rnd%0d_cnt", i), m_sc, m_fc);
      model_step(in);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
